spi_counter_tx: RTL



---
 rtl/spi_counter_tx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/spi_counter_tx.sv
// SPI mode-0 transmitter for the 14-bit counter snapshot plus run/clear bits.
// Define SPI_TX_CHECKSUM_EN to append an XOR checksum byte (24-bit frame).
module spi_counter_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] counter,
    input  logic        i_runstop,
    input  logic        i_clear,
    input  logic        send,
    output logic        busy,
    output logic        done,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n
);

`ifdef SPI_TX_CHECKSUM_EN
    localparam int N  = 24;
    localparam int BW = 5;
`else
    localparam int N  = 16;
    localparam int BW = 4;
`endif
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [N-1:0]    shreg;
    logic [7:0]      byte0;
    logic [7:0]      byte1;
    logic [N-1:0]    frame;
    logic            div_last;
    logic            bit_last;

    assign byte0 = {i_runstop, i_clear, counter[13:8]};
    assign byte1 = counter[7:0];

`ifdef SPI_TX_CHECKSUM_EN
    assign frame = {byte0, byte1, byte0 ^ byte1};
`else
    assign frame = {byte0, byte1};
`endif

    assign div_last = (div_cnt == DW'(CLK_DIV - 1));
    assign bit_last = (bit_cnt == BW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (send) begin
                        // MSB goes out now; the rest waits in shreg.
                        shreg   <= frame << 1;
                        mosi    <= frame[N-1];
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        sclk    <= 1'b0;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        if (sclk) begin
                            if (bit_last) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                mosi    <= shreg[N-1];
                                shreg   <= shreg << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        cs_n    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        mosi    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
